// File: rtl/leaf_pkg.sv
// ---------------------------------------------------------------------------
// leaf_pkg
// Shared leaf-wrapper definitions: payload/packet widths, the default
// stream-buffer geometry and the word/level typedefs built from them.
// No ports (package).
// ---------------------------------------------------------------------------
package leaf_pkg;

  localparam int LEAF_PAYLOAD_BITS  = 32;
  localparam int LEAF_PACKET_BITS   = 49;
  localparam int LEAF_BUF_DEPTH     = 16;
  localparam int LEAF_BUF_ADDR_BITS = 4;

  // One stream word as carried between the leaf interface and the kernel.
  typedef logic [LEAF_PAYLOAD_BITS-1:0] leaf_payload_t;

  // Occupancy 0..DEPTH needs one bit more than a pointer.
  typedef logic [LEAF_BUF_ADDR_BITS:0] leaf_level_t;

endpackage : leaf_pkg

// File: rtl/leaf_stream_buffer_mem.sv
// ---------------------------------------------------------------------------
// leaf_stream_buffer_mem
// DEPTH x PAYLOAD_BITS storage for the stream buffer. Synchronous write,
// asynchronous read, no reset, so it maps onto distributed RAM.
//
// Ports:
//   clk_user  in   write clock
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   write data
//   rd_addr   in   read address
//   rd_data   out  combinational read data at rd_addr
// ---------------------------------------------------------------------------
module leaf_stream_buffer_mem
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
  parameter int DEPTH        = LEAF_BUF_DEPTH,
  parameter int ADDR_BITS    = LEAF_BUF_ADDR_BITS
) (
  input  logic                    clk_user,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [PAYLOAD_BITS-1:0] rd_data
);

  logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk_user) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule : leaf_stream_buffer_mem

// File: rtl/leaf_stream_buffer.sv
// ---------------------------------------------------------------------------
// leaf_stream_buffer
// Elastic FIFO between the leaf interface user-side output stream and the
// HLS kernel input stream. Both ap_vld/ap_ack handshakes are driven only
// from registered state, so there is no combinational path from dout_ack
// to din_ack or from din_vld to dout_vld. A pushed word appears on dout
// one cycle after its push edge (no bypass).
//
// Ports:
//   clk_user   in   user clock
//   reset      in   asynchronous active-high reset
//   din        in   word from leaf interface
//   din_vld    in   word valid from leaf interface
//   din_ack    out  buffer can accept (not full)
//   dout       out  head word to kernel (asynchronous read of mem[rd_ptr])
//   dout_vld   out  buffer holds a word (not empty)
//   dout_ack   in   kernel accepts head word
//   level      out  occupancy 0..DEPTH
//
// Optional feature, macro LEAF_STREAM_BUFFER_STATS_EN:
//   stat_push_cnt  out  pushes since reset, wraps modulo 2^32
//   stat_pop_cnt   out  pops since reset, wraps modulo 2^32
//   stat_max_level out  highest occupancy since reset
// ---------------------------------------------------------------------------
module leaf_stream_buffer
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
  parameter int DEPTH        = LEAF_BUF_DEPTH,
  parameter int ADDR_BITS    = LEAF_BUF_ADDR_BITS
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [ADDR_BITS:0]      level
`ifdef LEAF_STREAM_BUFFER_STATS_EN
  , output logic [31:0]           stat_push_cnt
  , output logic [31:0]           stat_pop_cnt
  , output logic [ADDR_BITS:0]    stat_max_level
`endif
);

  localparam logic [ADDR_BITS:0]   FULL_LEVEL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   CNT_ZERO   = (ADDR_BITS+1)'(0);
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ZERO   = ADDR_BITS'(0);

  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] rd_ptr_r;
  logic [ADDR_BITS:0]   count_r;
  logic [ADDR_BITS:0]   count_nxt_s;
  logic                 din_ack_r;
  logic                 dout_vld_r;
  logic                 push_s;
  logic                 pop_s;

  // Transfers happen only against the registered handshake flags.
  assign push_s = din_vld & din_ack_r;
  assign pop_s  = dout_vld_r & dout_ack;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and the handshake flags, which are registered
  // copies of (count != DEPTH) and (count != 0) so they reset to their
  // idle values asynchronously and never see the opposite handshake.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      din_ack_r  <= 1'b1;
      dout_vld_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      din_ack_r  <= (count_nxt_s != FULL_LEVEL);
      dout_vld_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  leaf_stream_buffer_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH        (DEPTH),
    .ADDR_BITS    (ADDR_BITS)
  ) u_mem (
    .clk_user (clk_user),
    .wr_en    (push_s),
    .wr_addr  (wr_ptr_r),
    .wr_data  (din),
    .rd_addr  (rd_ptr_r),
    .rd_data  (dout)
  );

  assign din_ack  = din_ack_r;
  assign dout_vld = dout_vld_r;
  assign level    = count_r;

`ifdef LEAF_STREAM_BUFFER_STATS_EN
  logic [31:0]        stat_push_cnt_r;
  logic [31:0]        stat_pop_cnt_r;
  logic [ADDR_BITS:0] stat_max_level_r;

  // Transfer counters and occupancy high-water mark.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      stat_push_cnt_r  <= 32'd0;
      stat_pop_cnt_r   <= 32'd0;
      stat_max_level_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        stat_push_cnt_r <= stat_push_cnt_r + 32'd1;
      end
      if (pop_s) begin
        stat_pop_cnt_r <= stat_pop_cnt_r + 32'd1;
      end
      if (count_nxt_s > stat_max_level_r) begin
        stat_max_level_r <= count_nxt_s;
      end
    end
  end

  assign stat_push_cnt  = stat_push_cnt_r;
  assign stat_pop_cnt   = stat_pop_cnt_r;
  assign stat_max_level = stat_max_level_r;
`endif

endmodule : leaf_stream_buffer

// File: tb/tb_leaf_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_leaf_stream_buffer
// Self-checking bench for leaf_stream_buffer. The reference model is a
// queue of words: a push appends when the queue holds fewer than DEPTH
// words, a pop removes the head when the queue is non-empty.
// ---------------------------------------------------------------------------
module tb_leaf_stream_buffer;

  localparam int DEPTH = 16;

  logic        clk_user;
  logic        reset;
  logic [31:0] din;
  logic        din_vld;
  logic        din_ack;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_ack;
  logic [4:0]  level;
`ifdef LEAF_STREAM_BUFFER_STATS_EN
  logic [31:0] stat_push_cnt;
  logic [31:0] stat_pop_cnt;
  logic [4:0]  stat_max_level;
`endif

  int unsigned n_pass;
  int unsigned n_total;
  logic [31:0] q[$];
  int          peak;
  int          peak_rst;
  int unsigned mdl_push;
  int unsigned mdl_pop;

  leaf_stream_buffer dut (
    .clk_user (clk_user),
    .reset    (reset),
    .din      (din),
    .din_vld  (din_vld),
    .din_ack  (din_ack),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_ack (dout_ack),
    .level    (level)
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    , .stat_push_cnt  (stat_push_cnt)
    , .stat_pop_cnt   (stat_pop_cnt)
    , .stat_max_level (stat_max_level)
`endif
  );

  initial begin
    clk_user = 1'b0;
    forever #5 clk_user = ~clk_user;
  end

  // Advance one clock and update the queue model from the inputs held
  // across that edge.
  task automatic tick();
    logic        do_push;
    logic        do_pop;
    logic [31:0] d;
    do_push = din_vld && (q.size() != DEPTH);
    do_pop  = dout_ack && (q.size() != 0);
    d = din;
    @(posedge clk_user);
    #1;
    if (do_pop) begin
      d = d; // keep head removal explicit below
      q.delete(0);
      mdl_pop++;
    end
    if (do_push) begin
      q.push_back(d);
      mdl_push++;
    end
    if (q.size() > peak)     peak = q.size();
    if (q.size() > peak_rst) peak_rst = q.size();
  endtask

  task automatic model_clear();
    q.delete();
    peak = 0;
    peak_rst = 0;
    mdl_push = 0;
    mdl_pop = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; din_vld = 1'b0; dout_ack = 1'b0; din = 32'd0;
    #2;
    n_total++;
    if (din_ack !== 1'b1) $display("FAIL reset_din_ack: got %b expected 1", din_ack); else n_pass++;
    n_total++;
    if (dout_vld !== 1'b0) $display("FAIL reset_dout_vld: got %b expected 0", dout_vld); else n_pass++;
    n_total++;
    if (level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
    @(posedge clk_user);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_stream();
    peak = 0;
    dout_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din = 32'(i); din_vld = 1'b1;
      if (i > 1) begin
        n_total++;
        if (dout_vld !== 1'b1 || dout !== 32'(i - 1))
          $display("FAIL stream_dout: got vld=%b %h expected vld=1 %h", dout_vld, dout, 32'(i - 1));
        else n_pass++;
      end
      tick();
      n_total++;
      if (level !== 5'd1) $display("FAIL stream_level: got %0d expected 1", level); else n_pass++;
    end
    din_vld = 1'b0;
    n_total++;
    if (dout !== 32'd5) $display("FAIL stream_last: got %h expected 5", dout); else n_pass++;
    tick();
    n_total++;
    if (dout_vld !== 1'b0 || level !== 5'd0)
      $display("FAIL stream_empty: got vld=%b level=%0d expected vld=0 level=0", dout_vld, level);
    else n_pass++;
    n_total++;
    if (peak != 1) $display("FAIL stream_peak: got %0d expected 1", peak); else n_pass++;
  endtask

  task automatic test_fill();
    dout_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 32'hA0 + 32'(i); din_vld = 1'b1;
      n_total++;
      if (din_ack !== 1'b1) $display("FAIL fill_ack: got %b expected 1 at word %0d", din_ack, i); else n_pass++;
      tick();
      n_total++;
      if (level !== 5'(i + 1)) $display("FAIL fill_level: got %0d expected %0d", level, i + 1); else n_pass++;
    end
    din = 32'hB0;
    n_total++;
    if (din_ack !== 1'b0) $display("FAIL full_ack: got %b expected 0", din_ack); else n_pass++;
    tick();
    n_total++;
    if (level !== 5'd16 || din_ack !== 1'b0 || dout !== 32'hA0)
      $display("FAIL full_hold: got level=%0d ack=%b dout=%h expected 16 0 a0", level, din_ack, dout);
    else n_pass++;
  endtask

  task automatic test_pop_at_full();
    int budget;
    dout_ack = 1'b1;
    n_total++;
    if (dout !== 32'hA0 || dout_vld !== 1'b1 || din_ack !== 1'b0)
      $display("FAIL popfull_pre: got dout=%h vld=%b ack=%b expected a0 1 0", dout, dout_vld, din_ack);
    else n_pass++;
    tick();
    dout_ack = 1'b0;
    n_total++;
    if (level !== 5'd15 || din_ack !== 1'b1 || dout !== 32'hA1)
      $display("FAIL popfull_post: got level=%0d ack=%b dout=%h expected 15 1 a1", level, din_ack, dout);
    else n_pass++;
    tick();
    din_vld = 1'b0;
    n_total++;
    if (level !== 5'd16 || q[15] !== 32'hB0)
      $display("FAIL popfull_admit: got level=%0d expected 16", level);
    else n_pass++;
    dout_ack = 1'b1;
    budget = 0;
    while (q.size() > 0 && budget < 40) begin
      n_total++;
      if (dout !== q[0]) $display("FAIL drain_order: got %h expected %h", dout, q[0]); else n_pass++;
      tick();
      budget++;
    end
    n_total++;
    if (level !== 5'd0 || q.size() != 0) $display("FAIL drain_done: got level=%0d expected 0", level); else n_pass++;
    dout_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    dout_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = $urandom; din_vld = 1'b1;
      tick();
    end
    dout_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = $urandom;
      n_total++;
      if (level !== 5'd8 || dout !== q[0])
        $display("FAIL b2b: got level=%0d dout=%h expected 8 %h", level, dout, q[0]);
      else n_pass++;
      tick();
    end
    din_vld = 1'b0;
    while (q.size() > 0) tick();
    dout_ack = 1'b0;
  endtask

  task automatic test_random();
    int unsigned pushed0;
    int unsigned popped0;
    int          cyc;
    int unsigned errs;
    pushed0 = mdl_push;
    popped0 = mdl_pop;
    cyc = 0;
    errs = 0;
    while ((mdl_push - pushed0 < 1000 || q.size() > 0) && cyc < 20000) begin
      din_vld  = (mdl_push - pushed0 < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      din      = $urandom;
      dout_ack = 1'($urandom_range(0, 1));
      n_total++;
      if (din_ack !== (q.size() != DEPTH) || dout_vld !== (q.size() != 0) ||
          level !== 5'(q.size()) || (q.size() != 0 && dout !== q[0])) begin
        if (errs < 10)
          $display("FAIL random_cycle %0d: got ack=%b vld=%b level=%0d dout=%h expected level=%0d",
                   cyc, din_ack, dout_vld, level, dout, q.size());
        errs++;
      end else n_pass++;
      tick();
      cyc++;
    end
    din_vld = 1'b0; dout_ack = 1'b0;
    n_total++;
    if (mdl_pop - popped0 != 1000) $display("FAIL random_bound: got %0d pops expected 1000", mdl_pop - popped0); else n_pass++;
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    n_total++;
    if (stat_push_cnt !== 32'(mdl_push) || stat_pop_cnt !== 32'(mdl_pop) || stat_max_level !== 5'(peak_rst))
      $display("FAIL stats: got %0d %0d %0d expected %0d %0d %0d", stat_push_cnt, stat_pop_cnt,
               stat_max_level, mdl_push, mdl_pop, peak_rst);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    dout_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 32'h100 + 32'(i); din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    n_total++;
    if (level !== 5'd5) $display("FAIL areset_pre: got %0d expected 5", level); else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_total++;
    if (dout_vld !== 1'b0 || din_ack !== 1'b1 || level !== 5'd0)
      $display("FAIL areset_now: got vld=%b ack=%b level=%0d expected 0 1 0", dout_vld, din_ack, level);
    else n_pass++;
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    n_total++;
    if (stat_push_cnt !== 32'd0 || stat_pop_cnt !== 32'd0 || stat_max_level !== 5'd0)
      $display("FAIL areset_stats: got %0d %0d %0d expected 0 0 0", stat_push_cnt, stat_pop_cnt, stat_max_level);
    else n_pass++;
`endif
    model_clear();
    #2;
    reset = 1'b0;
    din = 32'h55; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    n_total++;
    if (dout_vld !== 1'b1 || dout !== 32'h55 || level !== 5'd1)
      $display("FAIL areset_first: got vld=%b dout=%h level=%0d expected 1 55 1", dout_vld, dout, level);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    model_clear();
    test_reset();
    test_stream();
    test_fill();
    test_pop_at_full();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_leaf_stream_buffer

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
- Elastic FIFO between the leaf interface's user-side output stream (ap_vld/ap_ack) and the HLS user kernel's input stream.
- Absorbs kernel stalls so the leaf interface keeps draining BFT packets, and decouples the two ap_hs handshakes with no combinational path between them.
- Sits in the leaf wrapper on the user clock domain, one instance per input port.

Parameters:
- PAYLOAD_BITS, 32, width of one stream word; matches the leaf interface payload width.
- DEPTH, 16, number of buffered words; must be a power of two and at least 2.
- ADDR_BITS, 4, log2(DEPTH); pointer width.

Ports:
- clk_user  in  1  user clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  PAYLOAD_BITS  word from leaf interface (dout_leaf_interface2user).
- din_vld  in  1  word valid from leaf interface.
- din_ack  out  1  acceptance to leaf interface.
- dout  out  PAYLOAD_BITS  word to user kernel (Input_x_V_V).
- dout_vld  out  1  word valid to kernel.
- dout_ack  in  1  acceptance from kernel.
- level  out  ADDR_BITS+1  current occupancy, 0..DEPTH.

Behaviour:
- Transfer rules:
  - Push occurs on an edge where din_vld=1 and din_ack=1.
  - Pop occurs on an edge where dout_vld=1 and dout_ack=1.
- Storage: circular buffer mem[DEPTH], wr_ptr and rd_ptr (ADDR_BITS each, wrap modulo DEPTH), count register (ADDR_BITS+1).
- Handshake outputs:
  - din_ack = (count != DEPTH); depends only on registered state, never on dout_ack.
  - dout_vld = (count != 0).
  - dout = mem[rd_ptr], asynchronous read; dout is held stable while dout_vld=1 and dout_ack=0.
- Latency: a word pushed at edge N is visible on dout with dout_vld=1 in the cycle after edge N. Minimum one cycle; no bypass path.
- Pointer and count updates:
  - Push only: wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count-1.
  - Push and pop on the same edge: both pointers advance, count unchanged, allowed at any non-full, non-empty level.
- Full (count==DEPTH): din_ack=0. A pop at full does not admit a push on the same edge; din_ack rises the following cycle.
- Empty (count==0): dout_vld=0. A push at empty is not forwarded on the same cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Order is strictly FIFO.
- level = count, registered.
- Reset, including assertion mid-transfer:
  - wr_ptr, rd_ptr and count go to 0.
  - din_ack=1 and dout_vld=0 immediately (asynchronous), so in-flight words are discarded.
  - dout reads mem[0]; memory contents are not cleared, and dout is don't-care while dout_vld=0.
  - level=0.
- No error or overflow states exist; the handshake makes overflow and underflow impossible.

Optional Feature:
- Macro LEAF_STREAM_BUFFER_STATS_EN.
- Defined: adds outputs stat_push_cnt (32), stat_pop_cnt (32) and stat_max_level (ADDR_BITS+1).
  - The counters increment on each push or pop and wrap modulo 2^32.
  - stat_max_level holds the highest count reached since reset.
  - All three reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package leaf_pkg holds:
  - constants LEAF_PAYLOAD_BITS=32 and LEAF_PACKET_BITS=49;
  - a payload word typedef;
  - a level typedef derived from ADDR_BITS.
- One sub-module, leaf_stream_buffer_mem: DEPTH x PAYLOAD_BITS storage with synchronous write and asynchronous read, so it maps to distributed RAM.
- Pointer, count and handshake logic stays in the top module.

Test Plan:
- Reset then stream: din_vld=1 with words 0x00000001..0x00000005, dout_ack=1 held.
  - Expect dout 1..5 in order, each one cycle after its push.
  - Expect level to peak at 1.
- Fill to full: push 16 words 0xA0..0xAF with dout_ack=0.
  - Expect din_ack=0 after the 16th push and level=16.
  - A 17th word held on din is not accepted.
- Pop at full: from the full state, pulse dout_ack for one cycle.
  - Expect dout 0xA0 consumed and level=15.
  - Expect din_ack=1 the next cycle and the held 17th word accepted, not on the pop cycle.
- Simultaneous push and pop at level 8: hold both handshakes for 20 cycles.
  - Expect level to stay 8 throughout.
  - Expect ordered output across pointer wrap (pointers pass 15->0).
- Random stalls: random din_vld and dout_ack at 50% with 1000 words.
  - Scoreboard shows exact in-order match, with no loss or duplication.
- Asynchronous reset mid-stream at level 5, asserted between edges.
  - Expect dout_vld=0, din_ack=1 and level=0 without waiting for a clock edge.
  - After release, a new word 0x55 is output first.
  - With LEAF_STREAM_BUFFER_STATS_EN defined, the stat counters read 0 after the reset.
